// File: rtl/key_event_if.sv
// Event stream from the keypad event queue to the hit judge.
// The master side presents the head event and occupancy; the slave side
// returns ev_ready to accept the head.
interface key_event_if #(
    parameter int TS_W  = 16,
    parameter int CNT_W = 3
);
    logic             ev_valid;
    logic             ev_ready;
    logic             ev_press;
    logic [1:0]       ev_lane;
    logic [TS_W-1:0]  ev_time;
    logic [CNT_W-1:0] ev_count;

    modport master (
        output ev_valid,
        output ev_press,
        output ev_lane,
        output ev_time,
        output ev_count,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_press,
        input  ev_lane,
        input  ev_time,
        input  ev_count,
        output ev_ready
    );
endinterface

// File: rtl/key_event_queue.sv
// Keypad event queue: turns level changes on four active-low key lanes into
// timestamped press/release events, serialises simultaneous edges by lane
// priority through per-lane pending slots, and buffers them in a small
// first-word-fall-through FIFO. Any event overwritten in a pending slot
// raises the sticky ovf flag.
module key_event_queue #(
    parameter int DEPTH    = 4,
    parameter int TS_W     = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keys,
    input  logic       clr_ovf,
    output logic       ovf,
    key_event_if.master ev
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW    = 1 + 2 + TS_W;

    // Lowest-indexed lane with its pending bit set (lane 0 has priority).
    function automatic logic [1:0] lowest_lane(input logic [3:0] p);
        logic [1:0] r;
        r = 2'd0;
        if (p[0])      r = 2'd0;
        else if (p[1]) r = 2'd1;
        else if (p[2]) r = 2'd2;
        else if (p[3]) r = 2'd3;
        return r;
    endfunction

    // Timebase
    logic [DIV_W-1:0] div_p0;
    logic [TS_W-1:0]  ts_p0;

    // Edge detect and pending slots
    logic [3:0]       keys_p0;
    logic [3:0]       vld_p0;
    logic [3:0]       pend_press_p0;
    logic [TS_W-1:0]  pend_time_p0 [4];

    // FIFO
    logic [EW-1:0]    mem_p1 [DEPTH];
    logic [AW-1:0]    wr_ptr_p1;
    logic [AW-1:0]    rd_ptr_p1;
    logic [CW-1:0]    count_p1;

    logic [3:0]       edges;
    logic [1:0]       sel;
    logic             vld_p1;
    logic             pop;
    logic             can_push;
    logic             push;
    logic [3:0]       xfer_vec;
    logic [3:0]       loss;
    logic [EW-1:0]    push_data;
    logic [EW-1:0]    head;

    // Transfer arbitration, loss detection and FIFO handshake decode.
    always_comb begin
        edges     = keys ^ keys_p0;
        sel       = lowest_lane(vld_p0);
        vld_p1    = (count_p1 != '0);
        pop       = vld_p1 & ev.ev_ready;
        can_push  = (count_p1 < CW'(DEPTH)) | pop;
        push      = (|vld_p0) & can_push;
        xfer_vec  = 4'b0000;
        if (push) xfer_vec[sel] = 1'b1;
        loss      = edges & vld_p0 & ~xfer_vec;
        push_data = {pend_press_p0[sel], sel, pend_time_p0[sel]};
        head      = mem_p1[rd_ptr_p1];
    end

    // Stage p0: tick divider and free-running timestamp (wraps, no saturation).
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_p0 <= '0;
            ts_p0  <= '0;
        end else if (div_p0 == DIV_W'(TICK_DIV - 1)) begin
            div_p0 <= '0;
            ts_p0  <= ts_p0 + TS_W'(1);
        end else begin
            div_p0 <= div_p0 + DIV_W'(1);
        end
    end

    // Stage p0: previous key levels for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) keys_p0 <= 4'b1111;
        else      keys_p0 <= keys;
    end

    // Stage p0: pending flags; a new edge reloads the slot even as it transfers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0 <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (edges[i])         vld_p0[i] <= 1'b1;
                else if (xfer_vec[i]) vld_p0[i] <= 1'b0;
            end
        end
    end

    // Stage p0: pending slot payload captured at the edge (data only, no reset).
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (edges[i]) begin
                pend_press_p0[i] <= ~keys[i];
                pend_time_p0[i]  <= ts_p0;
            end
        end
    end

    // Stage p1: FIFO storage write (data only, no reset).
    always_ff @(posedge clk) begin
        if (push) mem_p1[wr_ptr_p1] <= push_data;
    end

    // Stage p1: FIFO pointers and occupancy; push+pop keeps the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            count_p1  <= '0;
        end else begin
            if (push) wr_ptr_p1 <= (DEPTH > 1) ? wr_ptr_p1 + AW'(1) : '0;
            if (pop)  rd_ptr_p1 <= (DEPTH > 1) ? rd_ptr_p1 + AW'(1) : '0;
            case ({push, pop})
                2'b10:   count_p1 <= count_p1 + CW'(1);
                2'b01:   count_p1 <= count_p1 - CW'(1);
                default: count_p1 <= count_p1;
            endcase
        end
    end

    // Sticky overflow: a loss in the same cycle beats a clear request.
    always_ff @(posedge clk) begin
        if (!rst)          ovf <= 1'b0;
        else if (|loss)    ovf <= 1'b1;
        else if (clr_ovf)  ovf <= 1'b0;
    end

    // Head outputs are zeroed while the FIFO is empty.
    always_comb begin
        ev.ev_valid = vld_p1;
        ev.ev_count = count_p1;
        ev.ev_press = vld_p1 ? head[EW-1] : 1'b0;
        ev.ev_lane  = vld_p1 ? head[EW-2 -: 2] : 2'd0;
        ev.ev_time  = vld_p1 ? head[TS_W-1:0] : '0;
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Testbench for key_event_queue: directed key patterns with a scoreboard of
// expected events and a monitor that checks every accepted head event.
module tb_key_event_queue;

    localparam int DEPTH    = 4;
    localparam int TS_W     = 16;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 3;

    typedef struct packed {
        logic            press;
        logic [1:0]      lane;
        logic [TS_W-1:0] stamp;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keys;
    logic       clr_ovf;
    logic       ovf;

    key_event_if #(.TS_W(TS_W), .CNT_W(CNT_W)) bus ();

    key_event_queue #(
        .DEPTH(DEPTH),
        .TS_W(TS_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .keys(keys),
        .clr_ovf(clr_ovf),
        .ovf(ovf),
        .ev(bus)
    );

    always #5 clk = ~clk;

    ev_t        exp_q[$];
    ev_t        mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] cur_keys;

    // Cycles since the last reset edge; the DUT timestamp is cyc / TICK_DIV.
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a new key pattern; optionally queue the expected events in lane order.
    task automatic set_keys(input logic [3:0] k, input bit push);
        ev_t e;
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (k[i] != cur_keys[i]) begin
                    e.press = ~k[i];
                    e.lane  = 2'(i);
                    e.stamp = TS_W'(cyc / TICK_DIV);
                    exp_q.push_back(e);
                end
            end
        end
        cur_keys = k;
        keys     = k;
    endtask

    // Monitor: every accepted head event must match the scoreboard front.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got press=%0d lane=%0d time=%0d expected none",
                         bus.ev_press, bus.ev_lane, bus.ev_time);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.ev_press, bus.ev_lane, bus.ev_time} !== mon_e) begin
                    errors++;
                    $display("FAIL event: got press=%0d lane=%0d time=%0d expected press=%0d lane=%0d time=%0d",
                             bus.ev_press, bus.ev_lane, bus.ev_time,
                             mon_e.press, mon_e.lane, mon_e.stamp);
                end
            end
        end
    end

    initial begin
        int bad;
        rst          = 1'b0;
        keys         = 4'b1111;
        cur_keys     = 4'b1111;
        clr_ovf      = 1'b0;
        bus.ev_ready = 1'b0;

        // Reset state
        tick(3);
        check("rst_valid", int'(bus.ev_valid), 0);
        check("rst_count", int'(bus.ev_count), 0);
        check("rst_ovf",   int'(ovf), 0);
        check("rst_press", int'(bus.ev_press), 0);
        check("rst_lane",  int'(bus.ev_lane), 0);
        check("rst_time",  int'(bus.ev_time), 0);

        // Idle keys produce nothing
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick(1);
            if (bus.ev_valid !== 1'b0 || bus.ev_count !== '0 || ovf !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        // Single press on lane 2 at timestamp 3
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(12);
        bus.ev_ready = 1'b1;
        set_keys(4'b1011, 1'b1);
        tick(1);
        check("single_lat_k", int'(bus.ev_valid), 0);
        tick(1);
        check("single_valid", int'(bus.ev_valid), 1);
        check("single_press", int'(bus.ev_press), 1);
        check("single_lane",  int'(bus.ev_lane), 2);
        check("single_time",  int'(bus.ev_time), 3);
        tick(1);
        check("single_1cyc",  int'(bus.ev_valid), 0);
        set_keys(4'b1111, 1'b1);
        tick(4);
        check("single_drain", int'(bus.ev_count), 0);

        // Four simultaneous presses serialise by lane
        bus.ev_ready = 1'b0;
        set_keys(4'b0000, 1'b1);
        tick(1);
        check("simul_cnt0", int'(bus.ev_count), 0);
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check("simul_cnt", int'(bus.ev_count), i);
        end
        bus.ev_ready = 1'b1;
        tick(4);
        check("simul_drain", int'(bus.ev_count), 0);
        bus.ev_ready = 1'b0;

        // Fill the FIFO, then overflow lane 1's pending slot
        set_keys(4'b1111, 1'b1);
        tick(5);
        check("full_cnt", int'(bus.ev_count), 4);
        set_keys(4'b1101, 1'b0);
        tick(2);
        check("ovf_not_yet", int'(ovf), 0);
        set_keys(4'b1111, 1'b1);
        tick(1);
        check("ovf_set", int'(ovf), 1);
        check("ovf_cnt", int'(bus.ev_count), 4);

        // Pop and push in the same cycle while full
        bus.ev_ready = 1'b1;
        tick(1);
        bus.ev_ready = 1'b0;
        check("full_pushpop_cnt", int'(bus.ev_count), 4);
        tick(1);
        check("pend_cleared_cnt", int'(bus.ev_count), 4);
        bus.ev_ready = 1'b1;
        tick(5);
        bus.ev_ready = 1'b0;
        check("full_drain", int'(bus.ev_count), 0);
        check("full_sb_empty", exp_q.size(), 0);
        check("ovf_sticky", int'(ovf), 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("ovf_clr", int'(ovf), 0);

        // Reset mid-operation discards queued events and the timestamp
        set_keys(4'b1000, 1'b1);
        tick(5);
        check("pre_rst_cnt", int'(bus.ev_count), 3);
        exp_q.delete();
        rst      = 1'b0;
        keys     = 4'b1111;
        cur_keys = 4'b1111;
        tick(1);
        check("mid_rst_valid", int'(bus.ev_valid), 0);
        check("mid_rst_count", int'(bus.ev_count), 0);
        check("mid_rst_time",  int'(bus.ev_time), 0);
        rst = 1'b1;
        bus.ev_ready = 1'b1;
        set_keys(4'b1110, 1'b1);
        tick(2);
        check("post_rst_valid", int'(bus.ev_valid), 1);
        check("post_rst_lane",  int'(bus.ev_lane), 0);
        check("post_rst_time",  int'(bus.ev_time), 0);
        tick(1);
        check("post_rst_done", int'(bus.ev_valid), 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Consumes the 4-lane debounced keypad levels (active-low; idle 4'b1111) and converts level changes into timestamped press/release events.
- Events are buffered in a small FIFO with a valid/ready handshake toward the game-logic hit judge.
- Simultaneous edges are serialised by lane priority. Loss is reported, never silent.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- TS_W, 16, timestamp width in bits.
- TICK_DIV, 50000, clock cycles per timestamp increment; at least 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- keys  in  4  debounced key levels; 0 = pressed
- ev_ready  in  1  consumer accepts the head event
- clr_ovf  in  1  clears the ovf flag
- ev_valid  out  1  head event present
- ev_press  out  1  1 = press (1->0 edge), 0 = release (0->1 edge)
- ev_lane  out  2  lane index 0..3
- ev_time  out  TS_W  timestamp captured at the edge
- ev_count  out  $clog2(DEPTH)+1  FIFO occupancy
- ovf  out  1  sticky: an event was dropped

Behaviour:
- Reset: rst=0 sampled at a clk edge forces the following; reset mid-operation discards all queued and pending events.
  - key_prev = 4'b1111
  - timestamp = 0, divider = 0
  - all pending flags = 0
  - FIFO empty: ev_valid=0, ev_count=0
  - ovf=0, ev_press=0, ev_lane=0, ev_time=0
- Timestamp:
  - Divider counts 0..TICK_DIV-1.
  - Timestamp increments when the divider wraps. It wraps modulo 2^TS_W; there is no saturation.
- Edge detect:
  - Each cycle, lane i has an edge if keys[i] != key_prev[i].
  - key_prev <= keys every cycle.
  - On an edge, lane i's pending slot loads type (press = ~keys[i]) and the current timestamp value.
- Pending -> FIFO transfer:
  - At most one pending slot moves per cycle: the lowest-indexed lane with pending set.
  - Transfer is allowed when ev_count < DEPTH, or when a pop occurs in the same cycle.
  - The transferred slot clears unless the same lane has a new edge in that cycle, in which case it reloads with the new event. That is not a loss.
- Loss: ovf <= 1 when a lane has a new edge while its pending slot is set and is not transferring this cycle. The new event overwrites the old one.
- ovf clearing: ovf clears on clr_ovf=1 unless a loss occurs in the same cycle; loss wins.
- Latency:
  - Edge sampled at clk edge k sets pending at k.
  - With the FIFO not full and no lower-lane contention, the entry is written at k+1, so ev_valid=1 after k+1.
  - With 4 simultaneous edges the last event enters at k+4.
- FIFO:
  - First-word-fall-through: ev_* outputs show the head whenever ev_valid=1.
  - ev_valid = (ev_count != 0).
  - Pop occurs on ev_valid & ev_ready; ev_ready is ignored when empty.
  - Simultaneous push and pop leaves ev_count unchanged. This includes the full case.
  - Head outputs hold stable while ev_valid=1 and ev_ready=0.
- Full FIFO: pending slots wait; no FIFO entry is ever overwritten.
- Ordering:
  - Events from the same lane leave in edge order.
  - Across lanes, order is by transfer order (lane priority within a cycle).
- Idle: no edges means no events; keys held constant produces nothing.

Test Plan:
- Reset then keys=4'b1111 for 100 cycles -> ev_valid stays 0, ev_count=0, ovf=0.
- TICK_DIV=4; keys[2] 1->0 at edge where timestamp=3, ev_ready=1 -> one event: press=1, lane=2, time=3, ev_valid high for exactly 1 cycle.
- keys 4'b1111 -> 4'b0000 in one cycle, ev_ready=0 -> lanes 0,1,2,3 enter on consecutive cycles. ev_count reaches 4, all with the same time. Draining yields lane order 0,1,2,3.
- DEPTH=4 full with ev_ready=0; lane 1 toggles twice more (press, release) -> second toggle sets ovf=1. After draining, the queued lane-1 event is the release. clr_ovf=1 -> ovf=0.
- Full FIFO, ev_ready=1 and one pending lane in the same cycle -> ev_count stays 4, head advances, pending clears.
- Reset asserted with 3 events queued -> next cycle ev_valid=0, ev_count=0, timestamp=0. The first press after release of reset reports time=0.
